// File: rtl/rx_stream_arbiter_pkg.sv
// rx_stream_arbiter shared types and helpers.
// FSM state encoding and the SRC_WIDTH sizing function.
package rx_stream_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam int BURST_W = 8;

  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rx_stream_arbiter_stream_buf2.sv
// Two-entry first-word-fall-through buffer.
// DOUT shows the head entry whenever EMPTY is low.
module stream_buf2 #(
  parameter int W = 34
) (
  input  logic         BUS_CLK,
  input  logic         BUS_RST,
  input  logic         PUSH,
  input  logic [W-1:0] DIN,
  output logic         FULL,
  output logic         EMPTY,
  input  logic         POP,
  output logic [W-1:0] DOUT
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_q, wr_d;
  logic         rd_q, rd_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         push_ok, pop_ok;

  assign FULL    = (cnt_q == 2'd2);
  assign EMPTY   = (cnt_q == 2'd0);
  assign DOUT    = mem_q[rd_q];
  assign push_ok = PUSH & ~FULL;
  assign pop_ok  = POP & ~EMPTY;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok) begin
      mem_d[wr_q] = DIN;
      wr_d        = ~wr_q;
    end
    if (pop_ok) rd_d = ~rd_q;
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST) begin
    if (!BUS_RST) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rx_stream_arbiter.sv
// Round-robin merge of N FWFT receiver streams into one FWFT stream,
// with a per-grant burst limit and a 2-entry registered output buffer.
module rx_stream_arbiter
  import rx_stream_arbiter_pkg::*;
#(
  parameter int N_SRC      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int SRC_WIDTH  = 2,
  parameter int MAX_BURST  = 16
) (
  input  logic                        BUS_CLK,
  input  logic                        BUS_RST,
  input  logic [N_SRC-1:0]            SRC_ENABLE,
  input  logic [N_SRC-1:0]            IN_EMPTY,
  input  logic [N_SRC*DATA_WIDTH-1:0] IN_DATA,
  output logic [N_SRC-1:0]            IN_READ,
  output logic                        OUT_EMPTY,
  output logic [DATA_WIDTH-1:0]       OUT_DATA,
  output logic [SRC_WIDTH-1:0]        OUT_SRC,
  input  logic                        OUT_READ,
  output logic                        READ_ERROR
);

  localparam logic [BURST_W-1:0] MAX_B = BURST_W'(MAX_BURST);
  localparam int BW = SRC_WIDTH + DATA_WIDTH;

  if (SRC_WIDTH != clog2_min1(N_SRC)) begin : g_bad_src_width
    $error("SRC_WIDTH does not match N_SRC");
  end

  state_e               state_q, state_d;
  logic [SRC_WIDTH-1:0] grant_q, grant_d;
  logic [SRC_WIDTH-1:0] last_q, last_d;
  logic [BURST_W-1:0]   burst_q, burst_d;
  logic                 rerr_q, rerr_d;

  logic [N_SRC-1:0]      req;
  logic                  pick_vld;
  logic [SRC_WIDTH-1:0]  pick;
  logic                  pop;
  logic                  buf_full, buf_empty;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [BW-1:0]         buf_dout;

  assign req      = SRC_ENABLE & ~IN_EMPTY;
  assign sel_data = IN_DATA[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];

  // Scan downward so the nearest index after last_q wins.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    for (int k = N_SRC; k >= 1; k--) begin
      if (req[(int'(last_q) + k) % N_SRC]) begin
        pick_vld = 1'b1;
        pick     = SRC_WIDTH'((int'(last_q) + k) % N_SRC);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    burst_d = burst_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick;
          burst_d = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        pop = req[grant_q] & ~buf_full & (burst_q < MAX_B);
        if (pop) burst_d = burst_q + 1'b1;
        if (!req[grant_q] || burst_q >= MAX_B ||
            (pop && burst_q == MAX_B - 1'b1)) begin
          state_d = IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign IN_READ = pop ? (N_SRC'(1) << grant_q) : '0;
  assign rerr_d  = OUT_READ & buf_empty;

  always_ff @(posedge BUS_CLK or negedge BUS_RST) begin
    if (!BUS_RST) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= SRC_WIDTH'(N_SRC - 1);
      burst_q <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      rerr_q  <= rerr_d;
    end
  end

  stream_buf2 #(
    .W (BW)
  ) u_buf (
    .BUS_CLK (BUS_CLK),
    .BUS_RST (BUS_RST),
    .PUSH    (pop),
    .DIN     ({grant_q, sel_data}),
    .FULL    (buf_full),
    .EMPTY   (buf_empty),
    .POP     (OUT_READ),
    .DOUT    (buf_dout)
  );

  assign OUT_EMPTY  = buf_empty;
  assign OUT_DATA   = buf_dout[DATA_WIDTH-1:0];
  assign OUT_SRC    = buf_dout[BW-1:DATA_WIDTH];
  assign READ_ERROR = rerr_q;

endmodule

// File: tb/tb_rx_stream_arbiter.sv
// Directed bench for rx_stream_arbiter.
// Source FIFOs are modelled as arrays with head/tail indices.
module tb_rx_stream_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int SW = 2;
  localparam int MB = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  en;
  logic [N-1:0]  in_empty;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]  in_read;
  logic          out_empty;
  logic [DW-1:0] out_data;
  logic [SW-1:0] out_src;
  logic          out_read;
  logic          read_error;

  logic [DW-1:0] mem [N][64];
  int            hd [N];
  int            tl [N];

  logic [N-1:0]  s_rd;
  logic          s_emp, s_err, s_ord;
  logic [DW-1:0] s_data;
  logic [SW-1:0] s_src;

  logic [DW-1:0] od [256];
  logic [SW-1:0] os [256];
  int            on;
  int            pc [256];
  int            ps [256];
  int            pn;
  int            cc;
  int            onehot_viol;

  int n_run, n_fail;

  always #5 clk = ~clk;

  rx_stream_arbiter #(
    .N_SRC      (N),
    .DATA_WIDTH (DW),
    .SRC_WIDTH  (SW),
    .MAX_BURST  (MB)
  ) dut (
    .BUS_CLK    (clk),
    .BUS_RST    (rst_n),
    .SRC_ENABLE (en),
    .IN_EMPTY   (in_empty),
    .IN_DATA    (in_data),
    .IN_READ    (in_read),
    .OUT_EMPTY  (out_empty),
    .OUT_DATA   (out_data),
    .OUT_SRC    (out_src),
    .OUT_READ   (out_read),
    .READ_ERROR (read_error)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      in_empty[i] = (hd[i] == tl[i]);
      in_data[i*DW +: DW] = (hd[i] < tl[i]) ? mem[i][hd[i]] : '0;
    end
  endtask

  task automatic push(input int s, input logic [DW-1:0] v);
    mem[s][tl[s]] = v;
    tl[s]++;
    refresh();
  endtask

  task automatic cyc();
    @(negedge clk);
    s_rd   = in_read;
    s_emp  = out_empty;
    s_data = out_data;
    s_src  = out_src;
    s_err  = read_error;
    s_ord  = out_read;
    if ($countones(s_rd) > 1) onehot_viol++;
    if (!s_emp && s_ord && on < 256) begin
      od[on] = s_data;
      os[on] = s_src;
      on++;
    end
    for (int i = 0; i < N; i++) begin
      if (s_rd[i] && pn < 256) begin
        pc[pn] = cc;
        ps[pn] = i;
        pn++;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (s_rd[i] && hd[i] < tl[i]) hd[i]++;
    refresh();
    cc++;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    out_read = 1'b0;
    en       = '1;
    for (int i = 0; i < N; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    refresh();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    on = 0;
    pn = 0;
  endtask

  initial begin
    int nbad, ng, nb, k, e0, e1;
    int g [16];
    int bs [16];
    int exp_b [6];
    logic [N-1:0] rd_h [6];
    logic         emp_h [6];
    logic [DW-1:0] dat_h [6];
    logic [SW-1:0] src_h [6];

    n_run = 0;
    n_fail = 0;
    cc = 0;
    onehot_viol = 0;
    on = 0;
    pn = 0;
    rst_n = 1'b0;
    out_read = 1'b0;
    en = '1;
    for (int i = 0; i < N; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    refresh();

    // reset state
    #2;
    chk("rst_in_read", in_read, 0);
    chk("rst_out_empty", out_empty, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_src", out_src, 0);
    chk("rst_read_error", read_error, 0);

    // single source, three words
    do_reset();
    out_read = 1'b1;
    push(2, 32'hA1);
    push(2, 32'hA2);
    push(2, 32'hA3);
    for (int c = 0; c < 6; c++) begin
      cyc();
      rd_h[c]  = s_rd;
      emp_h[c] = s_emp;
      dat_h[c] = s_data;
      src_h[c] = s_src;
    end
    chk("t1_rd0", rd_h[0], 4'b0000);
    chk("t1_rd1", rd_h[1], 4'b0100);
    chk("t1_rd2", rd_h[2], 4'b0100);
    chk("t1_rd3", rd_h[3], 4'b0100);
    chk("t1_rd4", rd_h[4], 4'b0000);
    chk("t1_empty1", emp_h[1], 1);
    chk("t1_empty2", emp_h[2], 0);
    chk("t1_data2", dat_h[2], 32'hA1);
    chk("t1_src2", src_h[2], 2);
    chk("t1_data3", dat_h[3], 32'hA2);
    chk("t1_data4", dat_h[4], 32'hA3);
    chk("t1_src4", src_h[4], 2);
    chk("t1_empty5", emp_h[5], 1);

    // two heavy sources, burst limit
    do_reset();
    out_read = 1'b1;
    for (int i = 0; i < 40; i++) begin
      push(0, 32'h0000_0000 + i);
      push(1, 32'h0100_0000 + i);
    end
    k = 0;
    while (on < 80 && k < 400) begin
      cyc();
      k++;
    end
    chk("t2_words", on, 80);
    nbad = 0;
    e0 = 0;
    e1 = 0;
    for (int j = 0; j < 80; j++) begin
      int es;
      logic [DW-1:0] ed;
      es = (j < 64) ? ((j / 16) % 2) : ((j - 64) / 8);
      if (es == 0) begin
        ed = 32'h0000_0000 + e0;
        e0++;
      end else begin
        ed = 32'h0100_0000 + e1;
        e1++;
      end
      if (j < on && (int'(os[j]) != es || od[j] !== ed)) nbad++;
    end
    chk("t2_order_errs", nbad, 0);
    ng = 0;
    for (int j = 1; j < pn; j++) begin
      if (ps[j] != ps[j-1] && ng < 16) begin
        g[ng] = pc[j] - pc[j-1] - 1;
        ng++;
      end
    end
    chk("t2_bursts", ng, 5);
    nbad = 0;
    for (int j = 0; j < 4; j++)
      if (j >= ng || g[j] != 1) nbad++;
    chk("t2_gap_errs", nbad, 0);

    // backpressure: buffer fills, then drains
    do_reset();
    out_read = 1'b0;
    for (int i = 0; i < 5; i++) push(0, 32'h300 + i);
    repeat (8) cyc();
    chk("t3_pops_stalled", pn, 2);
    chk("t3_rd_stalled", s_rd, 0);
    chk("t3_empty_stalled", s_emp, 0);
    chk("t3_head_stalled", s_data, 32'h300);
    out_read = 1'b1;
    k = 0;
    while (on < 5 && k < 30) begin
      cyc();
      k++;
    end
    repeat (3) cyc();
    chk("t3_words", on, 5);
    chk("t3_pops", pn, 5);
    nbad = 0;
    for (int j = 0; j < on; j++)
      if (od[j] !== 32'h300 + j) nbad++;
    chk("t3_order_errs", nbad, 0);

    // source 2 disabled
    do_reset();
    en = 4'b1011;
    out_read = 1'b1;
    for (int i = 0; i < 18; i++)
      for (int s = 0; s < N; s++) push(s, (s << 8) | i);
    k = 0;
    while (pn < 54 && k < 400) begin
      cyc();
      k++;
    end
    repeat (4) cyc();
    nb = 0;
    for (int j = 0; j < pn; j++) begin
      if ((j == 0 || ps[j] != ps[j-1]) && nb < 16) begin
        bs[nb] = ps[j];
        nb++;
      end
    end
    exp_b = '{0, 1, 3, 0, 1, 3};
    chk("t4_bursts", nb, 6);
    nbad = 0;
    for (int j = 0; j < 6; j++)
      if (j >= nb || bs[j] != exp_b[j]) nbad++;
    chk("t4_grant_order_errs", nbad, 0);
    chk("t4_src2_left", tl[2] - hd[2], 18);

    // read while empty
    do_reset();
    out_read = 1'b0;
    cyc();
    out_read = 1'b1;
    cyc();
    chk("t5_err_early", s_err, 0);
    out_read = 1'b0;
    cyc();
    chk("t5_err_pulse", s_err, 1);
    chk("t5_empty_kept", s_emp, 1);
    cyc();
    chk("t5_err_clear", s_err, 0);
    chk("t5_empty_after", s_emp, 1);

    // reset mid-burst
    do_reset();
    out_read = 1'b1;
    for (int i = 0; i < 10; i++)
      for (int s = 0; s < N; s++) push(s, 32'h500 + (s << 4) + i);
    repeat (6) cyc();
    chk("t6_busy_before", out_empty, 0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_in_read", in_read, 0);
    chk("t6_rst_out_empty", out_empty, 1);
    chk("t6_rst_out_data", out_data, 0);
    chk("t6_rst_out_src", out_src, 0);
    chk("t6_rst_read_error", read_error, 0);
    cyc();
    chk("t6_rd_in_rst_a", s_rd, 0);
    cyc();
    chk("t6_rd_in_rst_b", s_rd, 0);
    rst_n = 1'b1;
    k = 0;
    s_rd = '0;
    while (s_rd == 0 && k < 10) begin
      cyc();
      k++;
    end
    chk("t6_first_grant", s_rd, 4'b0001);
    chk("t6_first_grant_lat", k, 2);

    chk("in_read_onehot_viol", onehot_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
